ascii_number_assembler: RTL and testbench



---
 rtl/ascii_pkg.sv | 22 ++
 rtl/ascii_char_classify.sv | 21 ++
 rtl/ascii_number_assembler.sv | 144 ++++++++++++++
 tb/tb_ascii_number_assembler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ascii_pkg.sv
// Shared definitions for the ASCII number assembler: character codes,
// assembler state encoding and default sizing.
package ascii_pkg;

    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_NINE  = 8'h39;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_BS    = 8'h08;

    // 999999 is the largest six-digit number and fits in 20 bits.
    localparam int VAL_W_DEF      = 20;
    localparam int MAX_DIGITS_DEF = 6;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        DISCARD = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } asmState_e;

endpackage

// File: rtl/ascii_char_classify.sv
// Combinational classifier for one ASCII character: decimal digit,
// terminator (CR or space) or backspace, plus the digit's numeric value.
module ascii_char_classify
    import ascii_pkg::*;
(
    input  logic [7:0] char_i,
    output logic       is_digit_o,
    output logic       is_term_o,
    output logic       is_bs_o,
    output logic [3:0] digit_o
);

    // The low nibble of '0'..'9' is already the digit value.
    always_comb begin
        is_digit_o = (char_i >= ASCII_ZERO) && (char_i <= ASCII_NINE);
        is_term_o  = (char_i == ASCII_CR) || (char_i == ASCII_SPACE);
        is_bs_o    = (char_i == ASCII_BS);
        digit_o    = char_i[3:0];
    end

endmodule

// File: rtl/ascii_number_assembler.sv
// Collects ASCII decimal digits (with backspace editing) into a buffer and,
// on a terminator, converts them to binary with a shift-add multiply-
// accumulate, one digit per cycle. The result or an error flag is offered
// on a valid/ready handshake.
module ascii_number_assembler
    import ascii_pkg::*;
#(
    parameter int MAX_DIGITS = MAX_DIGITS_DEF,
    parameter int VAL_W      = VAL_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       char_in,
    input  logic             char_valid,
    output logic             char_ready,
    output logic [VAL_W-1:0] num_out,
    output logic             num_error,
    output logic             num_valid,
    input  logic             num_ready
);

    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    asmState_e        state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [VAL_W-1:0] acc_q, acc_d;
    logic [3:0]       buf_q [MAX_DIGITS];
    logic [3:0]       buf_d [MAX_DIGITS];
    logic [VAL_W-1:0] numOut_q, numOut_d;
    logic             numError_q, numError_d;

    logic             isDigit;
    logic             isTerm;
    logic             isBs;
    logic [3:0]       digitVal;
    logic             accept;
    logic [VAL_W-1:0] macStep;

    ascii_char_classify u_classify (
        .char_i     (char_in),
        .is_digit_o (isDigit),
        .is_term_o  (isTerm),
        .is_bs_o    (isBs),
        .digit_o    (digitVal)
    );

    assign char_ready = (state_q == COLLECT) || (state_q == DISCARD);
    assign num_valid  = (state_q == DONE);
    assign num_out    = numOut_q;
    assign num_error  = numError_q;
    assign accept     = char_valid && char_ready;

    // Multiply by ten as (x<<3)+(x<<1) so no multiplier is inferred.
    assign macStep = (acc_q << 3) + (acc_q << 1) + VAL_W'(buf_q[idx_q]);

    // Next-state logic: character editing, conversion stepping, handshake.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        buf_d      = buf_q;
        numOut_d   = numOut_q;
        numError_d = numError_q;

        case (state_q)
            COLLECT: begin
                if (accept) begin
                    if (isDigit) begin
                        if (count_q == CNT_W'(MAX_DIGITS)) begin
                            state_d = DISCARD;
                        end else begin
                            buf_d[count_q] = digitVal;
                            count_d        = count_q + CNT_W'(1);
                        end
                    end else if (isBs) begin
                        if (count_q != '0) begin
                            count_d = count_q - CNT_W'(1);
                        end
                    end else if (isTerm) begin
                        if (count_q != '0) begin
                            state_d = CONVERT;
                            acc_d   = '0;
                            idx_d   = '0;
                        end
                    end else begin
                        state_d = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (accept && isTerm) begin
                    state_d    = DONE;
                    numError_d = 1'b1;
                    numOut_d   = '0;
                    count_d    = '0;
                end
            end
            CONVERT: begin
                acc_d = macStep;
                idx_d = idx_q + CNT_W'(1);
                if (idx_q == (count_q - CNT_W'(1))) begin
                    numOut_d   = macStep;
                    numError_d = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (num_ready) begin
                    state_d = COLLECT;
                    count_d = '0;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial number.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= COLLECT;
            count_q    <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            numOut_q   <= '0;
            numError_q <= 1'b0;
            for (int i = 0; i < MAX_DIGITS; i++) begin
                buf_q[i] <= 4'd0;
            end
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            numOut_q   <= numOut_d;
            numError_q <= numError_d;
            buf_q      <= buf_d;
        end
    end

endmodule

// File: tb/tb_ascii_number_assembler.sv
// Self-checking bench for ascii_number_assembler: a queue-based model of the
// editing/conversion rules is compared against the DUT every cycle, and
// directed sequences are pinned with hand-computed results.
module tb_ascii_number_assembler;

    logic        clk;
    logic        reset_n;
    logic [7:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [19:0] num_out;
    logic        num_error;
    logic        num_valid;
    logic        num_ready;

    int checks = 0;
    int errors = 0;

    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] SP = 8'h20;
    localparam logic [7:0] BS = 8'h08;

    ascii_number_assembler dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .num_out    (num_out),
        .num_error  (num_error),
        .num_valid  (num_valid),
        .num_ready  (num_ready)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: digits typed so far, discard flag, remaining conversion
    // cycles and the result currently on offer.
    int          digs[$];
    bit          discarding;
    int          busy;
    bit          haveRes;
    int          pendVal;
    logic [19:0] modelOut;
    logic        modelErr;

    task automatic checkValue(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: reacts to each accepted character per the rules,
    // computing the number with ordinary decimal arithmetic.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            digs.delete();
            discarding = 1'b0;
            busy       = 0;
            haveRes    = 1'b0;
            pendVal    = 0;
            modelOut   = '0;
            modelErr   = 1'b0;
        end else if (haveRes) begin
            if (num_ready) haveRes = 1'b0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                haveRes  = 1'b1;
                modelOut = 20'(pendVal);
                modelErr = 1'b0;
            end
        end else if (char_valid) begin
            bit isD, isT, isB;
            isD = (char_in >= 8'h30) && (char_in <= 8'h39);
            isT = (char_in == CR) || (char_in == SP);
            isB = (char_in == BS);
            if (discarding) begin
                if (isT) begin
                    discarding = 1'b0;
                    haveRes    = 1'b1;
                    modelOut   = '0;
                    modelErr   = 1'b1;
                    digs.delete();
                end
            end else if (isD) begin
                if (digs.size() == 6) discarding = 1'b1;
                else digs.push_back(int'(char_in) - 48);
            end else if (isB) begin
                if (digs.size() > 0) void'(digs.pop_back());
            end else if (isT) begin
                if (digs.size() > 0) begin
                    pendVal = 0;
                    foreach (digs[i]) pendVal = pendVal * 10 + digs[i];
                    busy = digs.size();
                    digs.delete();
                end
            end else begin
                discarding = 1'b1;
            end
        end
    end

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (reset_n) begin
            checkValue("char_ready", {19'd0, char_ready}, {19'd0, !haveRes && (busy == 0)});
            checkValue("num_valid", {19'd0, num_valid}, {19'd0, haveRes});
            checkValue("num_out", num_out, modelOut);
            if (haveRes) checkValue("num_error", {19'd0, num_error}, {19'd0, modelErr});
        end
    end

    // Offer one character and hold it until accepted; ends on a negedge.
    task automatic applyStimulus(input logic [7:0] c);
        int w;
        char_in    = c;
        char_valid = 1'b1;
        w = 0;
        while (!char_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!char_ready) begin
            errors++;
            $display("[TB] FAIL accept_timeout char=%02h waited=%0d required<200", c, w);
        end else begin
            @(posedge clk);
            @(negedge clk);
        end
        char_valid = 1'b0;
    endtask

    task automatic applyString(input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i]);
    endtask

    // Wait for a result, pin value/error/latency, then let the handshake run.
    task automatic checkOutput(input logic [19:0] expVal, input logic expErr, input int expLat);
        int lat;
        lat = 0;
        while (!num_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        checkValue("lit_valid", {19'd0, num_valid}, 20'd1);
        checkValue("lit_out", num_out, expVal);
        checkValue("lit_error", {19'd0, num_error}, {19'd0, expErr});
        checkValue("lit_latency", 20'(lat), 20'(expLat));
        if (num_ready) @(negedge clk);
    endtask

    // Directed scenarios.
    initial begin
        reset_n    = 1'b0;
        char_in    = 8'h00;
        char_valid = 1'b0;
        num_ready  = 1'b1;
        repeat (2) @(negedge clk);
        checkValue("rst_char_ready", {19'd0, char_ready}, 20'd1);
        checkValue("rst_num_valid", {19'd0, num_valid}, 20'd0);
        checkValue("rst_num_out", num_out, 20'd0);
        checkValue("rst_num_error", {19'd0, num_error}, 20'd0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] 123 CR");
        applyString("123"); applyStimulus(CR);
        checkOutput(20'h0007B, 1'b0, 3);

        $display("[TB] 999999 space");
        applyString("999999"); applyStimulus(SP);
        checkOutput(20'hF423F, 1'b0, 6);

        $display("[TB] seven nines");
        applyString("9999999"); applyStimulus(SP);
        checkOutput(20'd0, 1'b1, 0);

        $display("[TB] backspace editing");
        applyString("45"); applyStimulus(BS); applyString("7"); applyStimulus(CR);
        checkOutput(20'h0002F, 1'b0, 2);
        applyStimulus(BS); applyString("3"); applyStimulus(CR);
        checkOutput(20'd3, 1'b0, 1);

        $display("[TB] invalid character");
        applyString("1A2"); applyStimulus(CR);
        checkOutput(20'd0, 1'b1, 0);
        applyString("5"); applyStimulus(CR);
        checkOutput(20'd5, 1'b0, 1);

        $display("[TB] leading zeros");
        applyString("007"); applyStimulus(CR);
        checkOutput(20'd7, 1'b0, 3);

        $display("[TB] backpressure in DONE");
        num_ready = 1'b0;
        applyString("12"); applyStimulus(CR);
        char_in    = 8'h35;
        char_valid = 1'b1;
        checkOutput(20'd12, 1'b0, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkValue("hold_out", num_out, 20'd12);
            checkValue("hold_ready", {19'd0, char_ready}, 20'd0);
        end
        num_ready = 1'b1;
        applyStimulus(8'h35); applyStimulus(CR);
        checkOutput(20'd5, 1'b0, 1);

        $display("[TB] lone terminators");
        applyStimulus(CR); applyStimulus(SP); applyStimulus(SP);
        repeat (4) @(negedge clk);
        checkValue("lone_term_valid", {19'd0, num_valid}, 20'd0);

        $display("[TB] reset during convert");
        applyString("88888"); applyStimulus(CR);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkValue("midrst_valid", {19'd0, num_valid}, 20'd0);
        checkValue("midrst_ready", {19'd0, char_ready}, 20'd1);
        checkValue("midrst_out", num_out, 20'd0);
        checkValue("midrst_error", {19'd0, num_error}, 20'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (8) @(negedge clk);
        checkValue("midrst_no_valid", {19'd0, num_valid}, 20'd0);
        applyString("6"); applyStimulus(CR);
        checkOutput(20'd6, 1'b0, 1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

endmodule
